// File: rtl/cfg_ram_loader_if.sv
// rtl/cfg_ram_loader_if.sv - command handshake and shared SRAM write bus of the config loader
interface cfg_ram_loader_if #(
   parameter int DATA_WIDTH = 256
);
   logic                  s_valid;
   logic                  s_ready;
   logic [3:0]            s_ram_idx;
   logic [1:0]            s_addr;
   logic [DATA_WIDTH-1:0] s_data;
   logic [1:0]            addr_wr;
   logic [3:0]            sram_sel;
   logic                  wr_en;
   logic [63:0]           din;
   logic                  busy;
   logic                  done;
   logic                  err;

   modport slave (
      input  s_valid, s_ram_idx, s_addr, s_data,
      output s_ready, addr_wr, sram_sel, wr_en, din, busy, done, err
   );

   modport master (
      output s_valid, s_ram_idx, s_addr, s_data,
      input  s_ready, addr_wr, sram_sel, wr_en, din, busy, done, err
   );
endinterface

// File: rtl/cfg_ram_loader.sv
// rtl/cfg_ram_loader.sv - splits one wide config entry into 64-bit beats on the shared SRAM write bus
module cfg_ram_loader #(
   parameter int DATA_WIDTH = 256,
   parameter int RAM_GROUPS = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   cfg_ram_loader_if.slave bus
);
   localparam int RAM_NUM = DATA_WIDTH / 64;
   localparam int CW      = 5;

   typedef enum logic [1:0] {IDLE, WRITE, DONE, ERR} state_t;

   state_t                state_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [1:0]            addr_q;
   logic [3:0]            base_q;
   logic [CW-1:0]         cnt_q;

   logic                  s_ready_q;
   logic [1:0]            addr_wr_q;
   logic [3:0]            sram_sel_q;
   logic                  wr_en_q;
   logic [63:0]           din_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  err_q;

   logic                  accept_d;
   logic                  idx_ok_d;
   logic [3:0]            base_d;

   always_comb begin
      accept_d = bus.s_valid & s_ready_q;
      idx_ok_d = int'(bus.s_ram_idx) < RAM_GROUPS;
      base_d   = 4'(int'(bus.s_ram_idx) * RAM_NUM);
   end

   // Beat 0 is issued straight from the accept edge; later beats shift out of data_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         data_q     <= '0;
         addr_q     <= '0;
         base_q     <= '0;
         cnt_q      <= '0;
         s_ready_q  <= 1'b1;
         addr_wr_q  <= '0;
         sram_sel_q <= '0;
         wr_en_q    <= 1'b0;
         din_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         wr_en_q    <= 1'b0;
         addr_wr_q  <= '0;
         sram_sel_q <= '0;
         din_q      <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (accept_d) begin
                  if (idx_ok_d) begin
                     state_q    <= WRITE;
                     wr_en_q    <= 1'b1;
                     sram_sel_q <= base_d;
                     addr_wr_q  <= bus.s_addr;
                     din_q      <= bus.s_data[63:0];
                     data_q     <= bus.s_data >> 64;
                     addr_q     <= bus.s_addr;
                     base_q     <= base_d;
                     cnt_q      <= CW'(1);
                  end else begin
                     state_q <= ERR;
                     err_q   <= 1'b1;
                  end
                  s_ready_q <= 1'b0;
                  busy_q    <= 1'b1;
               end else begin
                  state_q   <= IDLE;
                  s_ready_q <= 1'b1;
                  busy_q    <= 1'b0;
               end
            end
            WRITE: begin
               if (cnt_q == CW'(RAM_NUM)) begin
                  state_q   <= DONE;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  s_ready_q <= 1'b1;
               end else begin
                  wr_en_q    <= 1'b1;
                  sram_sel_q <= base_q + 4'(cnt_q);
                  addr_wr_q  <= addr_q;
                  din_q      <= data_q[63:0];
                  data_q     <= data_q >> 64;
                  cnt_q      <= cnt_q + CW'(1);
               end
            end
            ERR: begin
               state_q   <= IDLE;
               s_ready_q <= 1'b1;
               busy_q    <= 1'b0;
            end
            default: begin
               state_q   <= IDLE;
               s_ready_q <= 1'b1;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.s_ready  = s_ready_q;
   assign bus.addr_wr  = addr_wr_q;
   assign bus.sram_sel = sram_sel_q;
   assign bus.wr_en    = wr_en_q;
   assign bus.din      = din_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
endmodule

// File: tb/tb_cfg_ram_loader.sv
// tb/tb_cfg_ram_loader.sv - directed scoreboard bench for cfg_ram_loader with a two-stage RAM receiver model
module tb_cfg_ram_loader;
   logic clk;
   logic rst_n;

   cfg_ram_loader_if #(.DATA_WIDTH(256)) bus_if ();

   cfg_ram_loader #(.DATA_WIDTH(256), .RAM_GROUPS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  sel;
      logic [1:0]  addr;
      logic [63:0] din;
   } beat_t;

   beat_t       exp_q[$];
   beat_t       mon_e;
   int          checks   = 0;
   int          errors   = 0;
   int          done_cnt = 0;
   int          d0;

   logic        st_v;
   logic [3:0]  st_sel;
   logic [1:0]  st_addr;
   logic [63:0] st_din;
   logic [63:0] ram [16][4];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_cmd(input int idx, input logic [1:0] addr, input logic [255:0] data, input int nbeats);
      for (int j = 0; j < nbeats; j++)
         exp_q.push_back('{sel: 4'(idx * 4 + j), addr: addr, din: data[64*j +: 64]});
   endtask

   task automatic drive(input logic [3:0] idx, input logic [1:0] addr, input logic [255:0] data);
      bus_if.s_valid   = 1'b1;
      bus_if.s_ram_idx = idx;
      bus_if.s_addr    = addr;
      bus_if.s_data    = data;
   endtask

   // Receiver: one register stage, then the RAM write; not tied to the loader reset.
   always @(posedge clk) begin
      st_v    <= bus_if.wr_en;
      st_sel  <= bus_if.sram_sel;
      st_addr <= bus_if.addr_wr;
      st_din  <= bus_if.din;
      if (st_v) ram[st_sel][st_addr] <= st_din;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus_if.done) done_cnt++;
         check("done_err_excl", 64'(bus_if.done & bus_if.err), 64'd0);
         if (bus_if.wr_en) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 64'd1, 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("beat_sram_sel", 64'(bus_if.sram_sel), 64'(mon_e.sel));
               check("beat_addr_wr", 64'(bus_if.addr_wr), 64'(mon_e.addr));
               check("beat_din", bus_if.din, mon_e.din);
            end
         end else begin
            check("idle_bus_zero", 64'(bus_if.addr_wr) | 64'(bus_if.sram_sel) | bus_if.din, 64'd0);
         end
      end
   end

   localparam logic [255:0] D1 = {64'hD, 64'hC, 64'hB, 64'hA};
   localparam logic [255:0] T0 = {64'h0000_0000_0000_0103, 64'h0000_0000_0000_0102,
                                  64'h0000_0000_0000_0101, 64'h0000_0000_0000_0100};
   localparam logic [255:0] T1 = {64'h3333_0000_0000_0003, 64'h3333_0000_0000_0002,
                                  64'h3333_0000_0000_0001, 64'h3333_0000_0000_0000};
   localparam logic [255:0] E1 = {64'hEEEE_0003, 64'hEEEE_0002, 64'hEEEE_0001, 64'hEEEE_0000};
   localparam logic [255:0] F1 = {64'hFFFF_0003, 64'hFFFF_0002, 64'hFFFF_0001, 64'hFFFF_0000};
   localparam logic [255:0] O1 = {64'h0D0D_0003, 64'h0D0D_0002, 64'h0D0D_0001, 64'h0D0D_0000};
   localparam logic [255:0] N1 = {64'h5A5A_0003, 64'h5A5A_0002, 64'h5A5A_0001, 64'h5A5A_0000};

   initial begin
      rst_n            = 1'b1;
      bus_if.s_valid   = 1'b0;
      bus_if.s_ram_idx = '0;
      bus_if.s_addr    = '0;
      bus_if.s_data    = '0;

      // Reset values before any clock edge
      #1 rst_n = 1'b0;
      #1;
      check("rst_s_ready", 64'(bus_if.s_ready), 64'd1);
      check("rst_wr_en", 64'(bus_if.wr_en), 64'd0);
      check("rst_addr_wr", 64'(bus_if.addr_wr), 64'd0);
      check("rst_sram_sel", 64'(bus_if.sram_sel), 64'd0);
      check("rst_din", bus_if.din, 64'd0);
      check("rst_busy", 64'(bus_if.busy), 64'd0);
      check("rst_done", 64'(bus_if.done), 64'd0);
      check("rst_err", 64'(bus_if.err), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Single write
      @(negedge clk);
      drive(4'd2, 2'd1, D1);
      push_cmd(2, 2'd1, D1, 4);
      @(negedge clk);
      bus_if.s_valid = 1'b0;
      check("t1_busy", 64'(bus_if.busy), 64'd1);
      check("t1_ready_low", 64'(bus_if.s_ready), 64'd0);
      check("t1_wr_en", 64'(bus_if.wr_en), 64'd1);
      repeat (3) begin
         @(negedge clk);
         check("t1_wr_en", 64'(bus_if.wr_en), 64'd1);
         check("t1_done_early", 64'(bus_if.done), 64'd0);
      end
      @(negedge clk);
      check("t1_done", 64'(bus_if.done), 64'd1);
      check("t1_busy_done", 64'(bus_if.busy), 64'd0);
      check("t1_ready_done", 64'(bus_if.s_ready), 64'd1);
      check("t1_wr_en_done", 64'(bus_if.wr_en), 64'd0);
      @(negedge clk);
      check("t1_done_pulse", 64'(bus_if.done), 64'd0);
      repeat (2) @(negedge clk);
      #1;
      for (int j = 0; j < 4; j++) check("t1_ram_word", ram[8+j][1], D1[64*j +: 64]);

      // Back-to-back with s_valid held
      @(negedge clk);
      d0 = done_cnt;
      drive(4'd0, 2'd2, T0);
      push_cmd(0, 2'd2, T0, 4);
      push_cmd(3, 2'd3, T1, 4);
      @(negedge clk);
      drive(4'd3, 2'd3, T1);
      check("t2_ready_low", 64'(bus_if.s_ready), 64'd0);
      repeat (3) begin
         @(negedge clk);
         check("t2_ready_low", 64'(bus_if.s_ready), 64'd0);
      end
      @(negedge clk);
      check("t2_ready_done", 64'(bus_if.s_ready), 64'd1);
      check("t2_gap_wr_en", 64'(bus_if.wr_en), 64'd0);
      @(negedge clk);
      bus_if.s_valid = 1'b0;
      check("t2_ready_low2", 64'(bus_if.s_ready), 64'd0);
      check("t2_wr_en2", 64'(bus_if.wr_en), 64'd1);
      repeat (3) begin
         @(negedge clk);
         check("t2_ready_low2", 64'(bus_if.s_ready), 64'd0);
      end
      @(negedge clk);
      check("t2_done2", 64'(bus_if.done), 64'd1);
      @(negedge clk);
      #1;
      check("t2_done_count", 64'(done_cnt - d0), 64'd2);
      check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

      // Invalid group index
      @(negedge clk);
      d0 = done_cnt;
      drive(4'd4, 2'd0, D1);
      @(negedge clk);
      bus_if.s_valid = 1'b0;
      check("t3_err", 64'(bus_if.err), 64'd1);
      check("t3_ready_low", 64'(bus_if.s_ready), 64'd0);
      check("t3_wr_en", 64'(bus_if.wr_en), 64'd0);
      check("t3_done", 64'(bus_if.done), 64'd0);
      @(negedge clk);
      check("t3_ready_back", 64'(bus_if.s_ready), 64'd1);
      check("t3_err_pulse", 64'(bus_if.err), 64'd0);
      check("t3_wr_en2", 64'(bus_if.wr_en), 64'd0);
      @(negedge clk);
      #1;
      check("t3_no_done", 64'(done_cnt - d0), 64'd0);

      // Inputs change while busy
      @(negedge clk);
      drive(4'd1, 2'd3, E1);
      push_cmd(1, 2'd3, E1, 4);
      push_cmd(1, 2'd0, F1, 4);
      @(negedge clk);
      drive(4'd1, 2'd0, F1);
      check("t4_ready_low", 64'(bus_if.s_ready), 64'd0);
      repeat (3) begin
         @(negedge clk);
         check("t4_ready_low", 64'(bus_if.s_ready), 64'd0);
      end
      @(negedge clk);
      check("t4_done", 64'(bus_if.done), 64'd1);
      @(negedge clk);
      bus_if.s_valid = 1'b0;
      check("t4_second_busy", 64'(bus_if.busy), 64'd1);
      repeat (3) @(negedge clk);
      @(negedge clk);
      check("t4_done2", 64'(bus_if.done), 64'd1);
      repeat (3) @(negedge clk);
      #1;
      check("t4_queue_empty", 64'(exp_q.size()), 64'd0);
      for (int j = 0; j < 4; j++) check("t4_ram_e", ram[4+j][3], E1[64*j +: 64]);

      // Reset in the middle of a command
      @(negedge clk);
      drive(4'd0, 2'd0, O1);
      push_cmd(0, 2'd0, O1, 4);
      @(negedge clk);
      bus_if.s_valid = 1'b0;
      repeat (7) @(negedge clk);
      drive(4'd0, 2'd0, N1);
      push_cmd(0, 2'd0, N1, 2);
      @(negedge clk);
      bus_if.s_valid = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("t5_wr_en_async", 64'(bus_if.wr_en), 64'd0);
      check("t5_din_async", bus_if.din, 64'd0);
      check("t5_sel_async", 64'(bus_if.sram_sel), 64'd0);
      check("t5_ready_async", 64'(bus_if.s_ready), 64'd1);
      check("t5_busy_async", 64'(bus_if.busy), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t5_ready_after", 64'(bus_if.s_ready), 64'd1);
      repeat (2) @(negedge clk);
      #1;
      check("t5_ram_u0_new", ram[0][0], N1[63:0]);
      check("t5_ram_u1_new", ram[1][0], N1[127:64]);
      check("t5_ram_u2_old", ram[2][0], O1[191:128]);
      check("t5_ram_u3_old", ram[3][0], O1[255:192]);
      check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
